// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the register-file write port among NUM_SRC writeback sources,
// with a one-cycle registered write, two-port bypass, and an optional busy scoreboard (RF_SCOREBOARD_EN).
module rf_write_arbiter #(
  parameter int NUM_SRC = 3,
  parameter int AW      = 5,
  parameter int DW      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC-1:0]    src_valid,
  output logic [NUM_SRC-1:0]    src_ready,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_SRC*DW-1:0] src_data,
  output logic                  rf_we,
  output logic [AW-1:0]         rf_waddr,
  output logic [DW-1:0]         rf_wdata,
  input  logic [AW-1:0]         rd_addr_a,
  input  logic [AW-1:0]         rd_addr_b,
  output logic                  byp_hit_a,
  output logic                  byp_hit_b,
  output logic [DW-1:0]         byp_data,
  output logic                  busy_a,
  output logic                  busy_b,
  input  logic                  resv_valid,
  input  logic [AW-1:0]         resv_addr
);

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [PW-1:0]      rr_ptr;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      ptr_next;
  logic               found;
  logic               accept;
  logic [NUM_SRC-1:0] grant;
  logic [AW-1:0]      addr_arr [NUM_SRC];
  logic [DW-1:0]      data_arr [NUM_SRC];

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign addr_arr[i] = src_addr[i*AW +: AW];
    assign data_arr[i] = src_data[i*DW +: DW];
  end

  // First valid source at or after rr_ptr, wrapping modulo NUM_SRC.
  always_comb begin
    int idx;
    idx     = 0;
    found   = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!found && src_valid[idx[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    grant = '0;
    if (found && reset) grant[gnt_idx] = 1'b1;
  end

  assign src_ready = grant;
  assign accept    = |grant;
  assign ptr_next  = (gnt_idx == PW'(NUM_SRC - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      rr_ptr   <= '0;
    end else if (accept) begin
      // Writes to register 0 are consumed but never reach the port.
      rf_we    <= |addr_arr[gnt_idx];
      rf_waddr <= addr_arr[gnt_idx];
      rf_wdata <= data_arr[gnt_idx];
      rr_ptr   <= ptr_next;
    end else begin
      rf_we    <= 1'b0;
    end
  end

  assign byp_hit_a = rf_we & (rf_waddr == rd_addr_a) & (|rd_addr_a);
  assign byp_hit_b = rf_we & (rf_waddr == rd_addr_b) & (|rd_addr_b);
  assign byp_data  = rf_wdata;

`ifdef RF_SCOREBOARD_EN
  logic [(1<<AW)-1:0] busy;
  logic [(1<<AW)-1:0] busy_next;

  // Clear first so a same-edge reservation of the written register wins.
  always_comb begin
    busy_next = busy;
    if (rf_we)      busy_next[rf_waddr]  = 1'b0;
    if (resv_valid) busy_next[resv_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busy_next;
  end

  assign busy_a = busy[rd_addr_a];
  assign busy_b = busy[rd_addr_b];
`else
  logic unused_resv;
  assign unused_resv = ^{resv_valid, resv_addr};
  assign busy_a      = 1'b0;
  assign busy_b      = 1'b0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Testbench for rf_write_arbiter: directed steps plus randomized traffic checked against a
// behavioural model of round-robin grant, one-cycle write issue, bypass and busy scoreboard.
module tb_rf_write_arbiter;
  localparam int NUM_SRC = 3;
  localparam int AW      = 5;
  localparam int DW      = 32;

  logic                  clk;
  logic                  reset;
  logic [NUM_SRC-1:0]    src_valid;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic [NUM_SRC*DW-1:0] src_data;
  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [DW-1:0]         rf_wdata;
  logic [AW-1:0]         rd_addr_a;
  logic [AW-1:0]         rd_addr_b;
  logic                  byp_hit_a;
  logic                  byp_hit_b;
  logic [DW-1:0]         byp_data;
  logic                  busy_a;
  logic                  busy_b;
  logic                  resv_valid;
  logic [AW-1:0]         resv_addr;

  rf_write_arbiter #(.NUM_SRC(NUM_SRC), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_addr(src_addr), .src_data(src_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b), .byp_data(byp_data),
    .busy_a(busy_a), .busy_b(busy_b),
    .resv_valid(resv_valid), .resv_addr(resv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Request-side view of each source
  logic [AW-1:0] pa [NUM_SRC];
  logic [DW-1:0] pd [NUM_SRC];

  // Reference model state
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  logic [31:0]   m_busy;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < NUM_SRC; i++) begin
      src_addr[i*AW +: AW] = pa[i];
      src_data[i*DW +: DW] = pd[i];
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_busy  = '0;
  endtask

  function automatic int model_grant();
    for (int k = 0; k < NUM_SRC; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM_SRC;
      if (((src_valid >> idx) & 3'b001) != 3'b000) return idx;
    end
    return -1;
  endfunction

  task automatic check_comb();
    int g;
    logic [NUM_SRC-1:0] exp_ready;
    logic exp_ba, exp_bb;
    g = model_grant();
    exp_ready = (g < 0) ? '0 : NUM_SRC'(1 << g);
`ifdef RF_SCOREBOARD_EN
    exp_ba = m_busy[rd_addr_a];
    exp_bb = m_busy[rd_addr_b];
`else
    exp_ba = 1'b0;
    exp_bb = 1'b0;
`endif
    check("src_ready", 64'(src_ready), 64'(exp_ready));
    check("rf_we",     64'(rf_we),     64'(m_we));
    check("rf_waddr",  64'(rf_waddr),  64'(m_waddr));
    check("rf_wdata",  64'(rf_wdata),  64'(m_wdata));
    check("byp_hit_a", 64'(byp_hit_a), 64'(m_we && m_waddr == rd_addr_a && rd_addr_a != 0));
    check("byp_hit_b", 64'(byp_hit_b), 64'(m_we && m_waddr == rd_addr_b && rd_addr_b != 0));
    check("byp_data",  64'(byp_data),  64'(m_wdata));
    check("busy_a",    64'(busy_a),    64'(exp_ba));
    check("busy_b",    64'(busy_b),    64'(exp_bb));
  endtask

  // One clock: check pre-edge outputs, advance model on the edge; returns the granted source or -1.
  task automatic step(output int g);
    check_comb();
    g = model_grant();
    @(posedge clk);
    if (m_we) m_busy[m_waddr] = 1'b0;
    if (resv_valid) m_busy[resv_addr] = 1'b1;
    m_busy[0] = 1'b0;
    if (g >= 0) begin
      m_we    = (pa[g] != 0);
      m_waddr = pa[g];
      m_wdata = pd[g];
      m_ptr   = (g + 1) % NUM_SRC;
    end else begin
      m_we = 1'b0;
    end
    #1;
  endtask

  task automatic do_reset();
    src_valid = '0;
    resv_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    int g;
    logic [DW-1:0] wv;
    src_valid = '0; resv_valid = 1'b0; resv_addr = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    for (int i = 0; i < NUM_SRC; i++) begin pa[i] = '0; pd[i] = '0; end
    pack();
    do_reset();

    check("rst_we", 64'(rf_we), 64'd0);
    check("rst_waddr", 64'(rf_waddr), 64'd0);
    check("rst_wdata", 64'(rf_wdata), 64'd0);
    for (int c = 0; c < 5; c++) step(g);

    // Source 1 alone
    pa[1] = 5'd5; pd[1] = 32'hDEADBEEF; pack();
    src_valid = 3'b010; #1;
    check("s1_ready", 64'(src_ready), 64'b010);
    step(g);
    src_valid = '0; #1;
    check("s1_we", 64'(rf_we), 64'd1);
    check("s1_waddr", 64'(rf_waddr), 64'd5);
    check("s1_wdata", 64'(rf_wdata), 64'hDEADBEEF);
    step(g);

    // All three valid from rr_ptr=0
    do_reset();
    for (int i = 0; i < NUM_SRC; i++) begin pa[i] = AW'(i + 1); pd[i] = 32'hA000_0000 + i; end
    pack();
    src_valid = 3'b111; #1;
    for (int c = 0; c < 6; c++) begin
      check("rr_order", 64'(src_ready), 64'(1 << (c % 3)));
      if (c > 0) check("rr_we", 64'(rf_we), 64'd1);
      step(g);
    end
    src_valid = '0; #1;
    check("rr_we_last", 64'(rf_we), 64'd1);
    step(g);

    // Write to register 0 is accepted but dropped
    pa[0] = '0; pd[0] = 32'h1234; pack();
    src_valid = 3'b001; #1;
    check("r0_ready", 64'(src_ready), 64'b001);
    step(g);
    src_valid = '0; #1;
    check("r0_we", 64'(rf_we), 64'd0);
    step(g);

    // Bypass
    pa[0] = 5'd7; pd[0] = 32'hCAFE_F00D; pack();
    src_valid = 3'b001; #1;
    step(g);
    src_valid = '0; rd_addr_a = 5'd7; rd_addr_b = 5'd8; #1;
    check("byp_a7", 64'(byp_hit_a), 64'd1);
    check("byp_b8", 64'(byp_hit_b), 64'd0);
    check("byp_val", 64'(byp_data), 64'hCAFE_F00D);
    step(g);

    // Asynchronous reset with a write in flight
    pa[1] = 5'd3; pd[1] = 32'h5555_AAAA; pack();
    src_valid = 3'b010; #1;
    step(g);
    #2 reset = 1'b0;
    #1;
    check("arst_we", 64'(rf_we), 64'd0);
    check("arst_ready", 64'(src_ready), 64'd0);
    check("arst_waddr", 64'(rf_waddr), 64'd0);
    model_reset();
    src_valid = '0;
    reset = 1'b1;
    step(g);

    // Scoreboard: same-edge clear and set of r9, then a plain write clears it
    rd_addr_a = 5'd9; rd_addr_b = 5'd0;
    resv_valid = 1'b1; resv_addr = 5'd9; #1;
    step(g);
    resv_valid = 1'b0;
    pa[0] = 5'd9; pd[0] = 32'h0909_0909; pack();
    src_valid = 3'b001; #1;
    step(g);
    src_valid = '0; resv_valid = 1'b1; resv_addr = 5'd9; #1;
    step(g);
    resv_valid = 1'b0; #1;
`ifdef RF_SCOREBOARD_EN
    check("sb_set_wins", 64'(busy_a), 64'd1);
`endif
    src_valid = 3'b001; #1;
    step(g);
    src_valid = '0; #1;
    step(g);
    check("sb_cleared", 64'(busy_a), 64'd0);

    // Randomized traffic; sources hold their request until granted
    src_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] == 1'b0 && $urandom_range(0, 1) == 1) begin
          src_valid[i] = 1'b1;
          pa[i] = AW'($urandom_range(0, 15));
          pd[i] = DW'($urandom);
        end
      end
      pack();
      rd_addr_a  = AW'($urandom_range(0, 15));
      rd_addr_b  = AW'($urandom_range(0, 15));
      resv_valid = ($urandom_range(0, 3) == 0);
      resv_addr  = AW'($urandom_range(0, 15));
      #1;
      step(g);
      if (g >= 0) src_valid[g] = 1'b0;
    end
    src_valid = '0; resv_valid = 1'b0; #1;
    step(g);
    step(g);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the register file's single write port among NUM_SRC writeback sources: ALU, load unit and multi-cycle mul/div.
- Round-robin arbitration with valid/ready handshakes per source; the winning write is registered and driven onto the register-file write port.
- Provides a two-read-port bypass so decode sees a write that is in flight on the port.
- Sits between the writeback stage and the register file.

Parameters:
- NUM_SRC, 3, number of writeback requesters (2..8).
- AW, 5, register address width.
- DW, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- src_valid  input  NUM_SRC  per-source write request.
- src_ready  output  NUM_SRC  per-source grant; one-hot or zero.
- src_addr  input  NUM_SRC*AW  packed destination registers; source i at [i*AW +: AW].
- src_data  input  NUM_SRC*DW  packed write data; source i at [i*DW +: DW].
- rf_we  output  1  register-file write enable.
- rf_waddr  output  AW  register-file write address.
- rf_wdata  output  DW  register-file write data.
- rd_addr_a  input  AW  decode read address A.
- rd_addr_b  input  AW  decode read address B.
- byp_hit_a  output  1  bypass valid for A.
- byp_hit_b  output  1  bypass valid for B.
- byp_data  output  DW  bypass data (equals rf_wdata).
- busy_a  output  1  scoreboard busy for A (see Optional Feature).
- busy_b  output  1  scoreboard busy for B (see Optional Feature).
- resv_valid  input  1  scoreboard reservation request (see Optional Feature).
- resv_addr  input  AW  register to reserve (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous): rf_we=0, rf_waddr=0, rf_wdata=0, rr_ptr=0, all scoreboard bits 0.
  - Any accepted-but-unissued write is discarded.
  - src_ready=0 while reset is low.
- Arbitration is combinational each cycle.
  - Search src_valid starting at index rr_ptr, wrapping modulo NUM_SRC; the first set bit is granted via src_ready[g]=1.
  - With no valid source, src_ready=0.
  - src_ready never asserts for a source whose valid is low.
- Acceptance happens when src_valid[g] & src_ready[g] at a rising edge.
  - Next cycle: rf_we=1 if src_addr[g]!=0, else rf_we=0. Writes to $0 are accepted but dropped.
  - Next cycle: rf_waddr=src_addr[g] and rf_wdata=src_data[g].
  - rr_ptr becomes (g+1) mod NUM_SRC.
- No acceptance in a cycle: next cycle rf_we=0; rf_waddr, rf_wdata and rr_ptr hold.
- Latency is exactly 1 cycle from acceptance to rf_we. The register file commits on the rising edge that ends the rf_we cycle.
- Throughput is one write per cycle. A continuously valid source is granted within NUM_SRC cycles (starvation bound).
- Sources must hold valid, addr and data stable until accepted. Data from the source is not registered before grant.
- Same destination from two sources in the same cycle: only the granted one is accepted. The other issues later, so the later grant overwrites.
- Bypass, combinational:
  - byp_hit_a = rf_we & (rf_waddr==rd_addr_a) & (rd_addr_a!=0); byp_hit_b likewise for rd_addr_b.
  - byp_data = rf_wdata.
  - The hit is 0 whenever rf_we=0.

Optional Feature:
- Macro RF_SCOREBOARD_EN.
- Defined:
  - A 2^AW-bit busy vector is kept. resv_valid with resv_addr!=0 sets busy[resv_addr] on the edge.
  - A write issued on the port (the edge ending an rf_we=1 cycle) clears busy[rf_waddr].
  - Set and clear of the same register on the same edge: set wins.
  - busy[0] is always 0.
  - busy_a=busy[rd_addr_a]; busy_b=busy[rd_addr_b]; both are combinational, from registered state.
- Not defined: busy_a=busy_b=0; resv_valid and resv_addr are ignored; no busy storage is synthesized.

Test Plan:
- Reset release, all src_valid=0 for 5 cycles -> rf_we=0, src_ready=0, rf_waddr=0, rf_wdata=0 every cycle.
- Source 1 alone, addr=5, data=0xDEADBEEF -> src_ready=3'b010 in that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
- All three sources valid for 6 cycles, rr_ptr=0 -> grants 0,1,2,0,1,2 in order; rf_we=1 on six consecutive cycles.
- Source 0 writes addr=0, data=0x1234 -> src_ready[0]=1 and the request is accepted; next cycle rf_we=0.
- Write addr=7 issued with rd_addr_a=7 and rd_addr_b=8 -> byp_hit_a=1, byp_hit_b=0, byp_data equals the written value. Also assert reset low mid-stream -> rf_we=0 immediately, in-flight write lost.
- RF_SCOREBOARD_EN: reserve r9, then later write r9 while a same-edge reserve of r9 occurs -> busy_a (rd_addr_a=9) stays 1. A write to r9 with no reserve -> busy_a=0 the next cycle.
